// File: rtl/alu_writeback.sv
// ALU result write-back: FIFO of ALU results, ARM condition check, register-file write and CPSR flags.
// Define ALU_WB_STATS_EN to add retired/annulled entry counters.
module alu_writeback #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             in_Clk,
    input  logic             in_Rst_n,
    input  logic             in_Valid,
    output logic             out_Ready,
    input  logic [WIDTH-1:0] in_Y,
    input  logic [3:0]       in_CNZV,
    input  logic [3:0]       in_Cond,
    input  logic             in_SetFlags,
    input  logic             in_WriteRd,
    input  logic [3:0]       in_Rd,
    input  logic             in_Flush,
    input  logic             in_WbReady,
    output logic             out_RegWrEn,
    output logic [3:0]       out_RegWrAddr,
    output logic [WIDTH-1:0] out_RegWrData,
    output logic [3:0]       out_Flags
`ifdef ALU_WB_STATS_EN
    ,
    output logic [15:0]      out_RetiredCnt,
    output logic [15:0]      out_AnnulledCnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [3:0]       cnzv;
        logic [3:0]       cond;
        logic             set_flags;
        logic             write_rd;
        logic [3:0]       rd;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       flags;
    logic             empty;
    logic             full;
    logic             pass;
    logic             enq;
    logic             deq;

    // ARM condition field against flags {C,N,Z,V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic c, n, z, v, r;
        c = f[3];
        n = f[2];
        z = f[1];
        v = f[0];
        case (cond)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        head          = mem[rd_ptr];
        empty         = (count == '0);
        full          = (count == CNT_W'(DEPTH));
        pass          = cond_pass(head.cond, flags);
        enq           = in_Valid & ~full & ~in_Flush;
        // failing or non-writing heads leave immediately; writers wait for the port
        deq           = ~empty & ~in_Flush & (~pass | ~head.write_rd | in_WbReady);
        out_Ready     = ~full;
        out_RegWrEn   = ~empty & ~in_Flush & pass & head.write_rd;
        out_RegWrAddr = head.rd;
        out_RegWrData = head.y;
        out_Flags     = flags;
    end

    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (enq) begin
            mem[wr_ptr] <= '{y: in_Y, cnzv: in_CNZV, cond: in_Cond, set_flags: in_SetFlags,
                             write_rd: in_WriteRd, rd: in_Rd};
        end
    end

    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (in_Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // flags only move on an in-order retire, so the next head sees them one cycle later
    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            flags <= 4'b0000;
        end else if (deq && pass && head.set_flags) begin
            flags <= head.cnzv;
        end
    end

`ifdef ALU_WB_STATS_EN
    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            out_RetiredCnt  <= 16'h0000;
            out_AnnulledCnt <= 16'h0000;
        end else if (deq) begin
            if (pass) out_RetiredCnt  <= out_RetiredCnt + 16'h0001;
            else      out_AnnulledCnt <= out_AnnulledCnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized scoreboard bench for alu_writeback: an in-order ARM condition model predicts every
// register write; a forked monitor pops and compares each committed write.
module tb_alu_writeback;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic             ready;
    logic [WIDTH-1:0] y = '0;
    logic [3:0]       cnzv = '0;
    logic [3:0]       cond = '0;
    logic             set_flags = 1'b0;
    logic             write_rd = 1'b0;
    logic [3:0]       rd = '0;
    logic             flush = 1'b0;
    logic             wb_ready = 1'b0;
    logic             reg_wr_en;
    logic [3:0]       reg_wr_addr;
    logic [WIDTH-1:0] reg_wr_data;
    logic [3:0]       flags;
`ifdef ALU_WB_STATS_EN
    logic [15:0]      retired_cnt;
    logic [15:0]      annulled_cnt;
`endif

    typedef struct {
        logic [3:0]       rd;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t        sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] m_flags = 4'b0000;
    int         m_pass = 0;
    int         m_annul = 0;
    bit         rand_wb = 1'b0;

    alu_writeback #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .in_Clk        (clk),
        .in_Rst_n      (rst_n),
        .in_Valid      (valid),
        .out_Ready     (ready),
        .in_Y          (y),
        .in_CNZV       (cnzv),
        .in_Cond       (cond),
        .in_SetFlags   (set_flags),
        .in_WriteRd    (write_rd),
        .in_Rd         (rd),
        .in_Flush      (flush),
        .in_WbReady    (wb_ready),
        .out_RegWrEn   (reg_wr_en),
        .out_RegWrAddr (reg_wr_addr),
        .out_RegWrData (reg_wr_data),
        .out_Flags     (flags)
`ifdef ALU_WB_STATS_EN
        ,
        .out_RetiredCnt  (retired_cnt),
        .out_AnnulledCnt (annulled_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: ARM condition semantics on {C,N,Z,V}
    function automatic bit ref_pass(input logic [3:0] c_f, input logic [3:0] f);
        bit c = f[3];
        bit n = f[2];
        bit z = f[1];
        bit v = f[0];
        case (c_f)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && reg_wr_en && wb_ready && !flush) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_unexpected: got write r%0d=%0h required none",
                             reg_wr_addr, reg_wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_addr", 64'(reg_wr_addr), 64'(e.rd));
                    chk("wb_data", 64'(reg_wr_data), 64'(e.data));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_wb) wb_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Present one result until accepted; the model then predicts its architectural effect.
    task automatic issue(input logic [3:0] c_f, input logic [3:0] f, input bit s, input bit w,
                         input logic [3:0] r, input logic [WIDTH-1:0] d, input bit model);
        int budget = 200;
        bit acc = 1'b0;
        valid = 1'b1; cond = c_f; cnzv = f; set_flags = s; write_rd = w; rd = r; y = d;
        while (!acc && budget > 0) begin
            if (rand_wb) wb_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
            budget--;
        end
        valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got ready=0 for 200 cycles required accept");
        end else if (model) begin
            if (ref_pass(c_f, m_flags)) begin
                m_pass++;
                if (s) m_flags = f;
                if (w) sb.push_back('{r, d});
            end else begin
                m_annul++;
            end
        end
    endtask

    task automatic drain();
        int budget = 100;
        rand_wb = 1'b0;
        wb_ready = 1'b1;
        while (sb.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        idle(3);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_ready", 64'(ready), 64'd1);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_wren", 64'(reg_wr_en), 64'd0);
        chk("rst_addr", 64'(reg_wr_addr), 64'd0);
        chk("rst_data", 64'(reg_wr_data), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: unconditional write appears the cycle after enqueue
        wb_ready = 1'b1;
        issue(4'hE, 4'b0000, 1'b0, 1'b1, 4'd3, 32'd5, 1'b1);
        chk("t1_wren", 64'(reg_wr_en), 64'd1);
        chk("t1_addr", 64'(reg_wr_addr), 64'd3);
        chk("t1_data", 64'(reg_wr_data), 64'd5);
        drain();

        // 2: ADDS sets Z, MOVEQ executes, MOVNE annulled
        issue(4'hE, 4'b0010, 1'b1, 1'b1, 4'd0, 32'd0, 1'b1);
        idle(1);
        chk("t2_flags_after_adds", 64'(flags), 64'b0010);
        issue(4'h0, 4'b0000, 1'b0, 1'b1, 4'd1, 32'd7, 1'b1);
        issue(4'h1, 4'b0000, 1'b0, 1'b1, 4'd2, 32'd9, 1'b1);
        drain();
        chk("t2_flags", 64'(flags), 64'b0010);

        // 3: backpressure from the register file
        wb_ready = 1'b0;
        issue(4'hE, 4'b0000, 1'b0, 1'b1, 4'd4, 32'h11, 1'b1);
        issue(4'hE, 4'b0000, 1'b0, 1'b1, 4'd5, 32'h22, 1'b1);
        chk("t3_ready_full", 64'(ready), 64'd0);
        chk("t3_head_addr", 64'(reg_wr_addr), 64'd4);
        idle(2);
        chk("t3_hold_wren", 64'(reg_wr_en), 64'd1);
        chk("t3_hold_addr", 64'(reg_wr_addr), 64'd4);
        chk("t3_hold_data", 64'(reg_wr_data), 64'h11);
        fork
            issue(4'hE, 4'b0000, 1'b0, 1'b1, 4'd6, 32'h33, 1'b1);
            begin
                idle(3);
                wb_ready = 1'b1;
            end
        join
        drain();

        // 4: flush of a full FIFO with a concurrent enqueue
        wb_ready = 1'b0;
        issue(4'hE, 4'b1111, 1'b1, 1'b1, 4'd8, 32'hAA, 1'b0);
        issue(4'hE, 4'b1111, 1'b1, 1'b1, 4'd9, 32'hBB, 1'b0);
        valid = 1'b1; cond = 4'hE; write_rd = 1'b1; rd = 4'd10; y = 32'hCC;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        chk("t4_ready", 64'(ready), 64'd1);
        chk("t4_wren", 64'(reg_wr_en), 64'd0);
        chk("t4_flags", 64'(flags), 64'(m_flags));
        wb_ready = 1'b1;
        idle(3);
        chk("t4_wren_after", 64'(reg_wr_en), 64'd0);

        // 5: NV condition never executes; asynchronous reset mid-stall
        issue(4'hF, 4'b1111, 1'b1, 1'b1, 4'd6, 32'hDEAD, 1'b1);
        drain();
        chk("t5_nv_flags", 64'(flags), 64'(m_flags));
        wb_ready = 1'b0;
        issue(4'hE, 4'b0000, 1'b0, 1'b1, 4'd7, 32'hAB, 1'b1);
        idle(1);
        chk("t5_stall_wren", 64'(reg_wr_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 64'(ready), 64'd1);
        chk("t5_rst_wren", 64'(reg_wr_en), 64'd0);
        chk("t5_rst_addr", 64'(reg_wr_addr), 64'd0);
        chk("t5_rst_data", 64'(reg_wr_data), 64'd0);
        chk("t5_rst_flags", 64'(flags), 64'd0);
        sb.delete();
        m_flags = 4'b0000;
        m_pass = 0;
        m_annul = 0;
        idle(2);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        idle(3);
        chk("t5_post_rst_wren", 64'(reg_wr_en), 64'd0);

        // random traffic with random register-file backpressure
        rand_wb = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), 32'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();
        chk("rand_flags", 64'(flags), 64'(m_flags));
`ifdef ALU_WB_STATS_EN
        chk("stats_retired", 64'(retired_cnt), 64'(m_pass));
        chk("stats_annulled", 64'(annulled_cnt), 64'(m_annul));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
